// File: rtl/alu_share_arbiter_if.sv
// Per-requester handshake bundle for alu_share_arbiter: request channel in, response channel out.
// master = requester side, slave = arbiter side.
interface alu_share_arbiter_if #(
  parameter int DW = 32,
  parameter int CW = 4
);
  logic          req_valid;
  logic          req_ready;
  logic [DW-1:0] req_a;
  logic [DW-1:0] req_b;
  logic [CW-1:0] req_ctl;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_zero;
  logic          rsp_ovf;

  modport master (
    output req_valid, req_a, req_b, req_ctl, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_zero, rsp_ovf
  );

  modport slave (
    input  req_valid, req_a, req_b, req_ctl, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_zero, rsp_ovf
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters; one grant per cycle,
// result captured into a one-entry response buffer per port.
module alu_share_arbiter #(
  parameter int DW    = 32,
  parameter int CW    = 4,
  parameter int RR_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  alu_share_arbiter_if.slave p0,
  alu_share_arbiter_if.slave p1,
  output logic [DW-1:0]     alu_da,
  output logic [DW-1:0]     alu_db,
  output logic [CW-1:0]     alu_ctl,
  input  logic [DW-1:0]     alu_dc,
  input  logic              alu_zero,
  input  logic              alu_ovf,
  output logic              busy
);

  typedef enum logic {PORT0 = 1'b0, PORT1 = 1'b1} port_e;

  port_e         last_grant;
  logic [1:0]    req_valid;
  logic [1:0]    rsp_ready;
  logic [1:0]    eligible;
  logic [1:0]    grant;
  logic [DW-1:0] req_a   [2];
  logic [DW-1:0] req_b   [2];
  logic [CW-1:0] req_ctl [2];

  logic [1:0]    rsp_valid_q;
  logic [1:0]    rsp_zero_q;
  logic [1:0]    rsp_ovf_q;
  logic [DW-1:0] rsp_data_q [2];

  assign req_valid  = {p1.req_valid, p0.req_valid};
  assign rsp_ready  = {p1.rsp_ready, p0.rsp_ready};
  assign req_a[0]   = p0.req_a;
  assign req_a[1]   = p1.req_a;
  assign req_b[0]   = p0.req_b;
  assign req_b[1]   = p1.req_b;
  assign req_ctl[0] = p0.req_ctl;
  assign req_ctl[1] = p1.req_ctl;

  // A full buffer still accepts when it is being popped in the same cycle.
  assign eligible = req_valid & (~rsp_valid_q | rsp_ready);

  always_comb begin
    grant = '0;
    if (!rst) begin
      case (eligible)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = ((RR_EN != 0) && (last_grant == PORT0)) ? 2'b10 : 2'b01;
        default: grant = '0;
      endcase
    end
  end

  always_comb begin
    alu_da  = '0;
    alu_db  = '0;
    alu_ctl = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      if (grant[i]) begin
        alu_da  = req_a[i];
        alu_db  = req_b[i];
        alu_ctl = req_ctl[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= '0;
      rsp_zero_q  <= '0;
      rsp_ovf_q   <= '0;
      for (int unsigned i = 0; i < 2; i++) rsp_data_q[i] <= '0;
      last_grant  <= PORT1;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        // Grant wins over pop so a same-cycle pop+grant refills the buffer.
        if (grant[i]) begin
          rsp_valid_q[i] <= 1'b1;
          rsp_data_q[i]  <= alu_dc;
          rsp_zero_q[i]  <= alu_zero;
          rsp_ovf_q[i]   <= alu_ovf;
        end else if (rsp_ready[i]) begin
          rsp_valid_q[i] <= 1'b0;
        end
      end
      if (grant[1])      last_grant <= PORT1;
      else if (grant[0]) last_grant <= PORT0;
    end
  end

  assign p0.req_ready = grant[0];
  assign p1.req_ready = grant[1];
  assign p0.rsp_valid = rsp_valid_q[0];
  assign p1.rsp_valid = rsp_valid_q[1];
  assign p0.rsp_data  = rsp_data_q[0];
  assign p1.rsp_data  = rsp_data_q[1];
  assign p0.rsp_zero  = rsp_zero_q[0];
  assign p1.rsp_zero  = rsp_zero_q[1];
  assign p0.rsp_ovf   = rsp_ovf_q[0];
  assign p1.rsp_ovf   = rsp_ovf_q[1];
  assign busy         = |rsp_valid_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed literal cases plus randomized traffic
// checked every cycle against a transaction-level model of the arbiter.
module tb_alu_share_arbiter;
  localparam int DW = 32;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_share_arbiter_if #(.DW(DW), .CW(CW)) p0_if ();
  alu_share_arbiter_if #(.DW(DW), .CW(CW)) p1_if ();
  alu_share_arbiter_if #(.DW(DW), .CW(CW)) q0_if ();
  alu_share_arbiter_if #(.DW(DW), .CW(CW)) q1_if ();

  logic [DW-1:0] da, db, dc, fda, fdb, fdc;
  logic [CW-1:0] ctl, fctl;
  logic          zf, of, fzf, fof, busy, fbusy;

  int checks = 0;
  int errors = 0;

  // Reference ALU: returns {ovf, zero, result}
  function automatic logic [DW+1:0] alu_f(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic [CW-1:0] c);
    logic [DW-1:0] r;
    logic          o;
    r = '0;
    o = 1'b0;
    case (c)
      4'd0, 4'd1: begin
        r = a + b;
        o = (a[DW-1] == b[DW-1]) && (r[DW-1] != a[DW-1]);
      end
      4'd2: begin
        r = a - b;
        o = (a[DW-1] != b[DW-1]) && (r[DW-1] != a[DW-1]);
      end
      4'd3: r = a & b;
      4'd4: r = a | b;
      4'd5: r = a ^ b;
      4'd6: r = a << b[4:0];
      4'd7: r = a >> b[4:0];
      default: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
    return {o, (r == '0), r};
  endfunction

  assign {of, zf, dc}    = alu_f(da, db, ctl);
  assign {fof, fzf, fdc} = alu_f(fda, fdb, fctl);

  alu_share_arbiter #(.DW(DW), .CW(CW), .RR_EN(1)) dut (
    .clk(clk), .rst(rst), .p0(p0_if.slave), .p1(p1_if.slave),
    .alu_da(da), .alu_db(db), .alu_ctl(ctl),
    .alu_dc(dc), .alu_zero(zf), .alu_ovf(of), .busy(busy)
  );

  alu_share_arbiter #(.DW(DW), .CW(CW), .RR_EN(0)) dut_fp (
    .clk(clk), .rst(rst), .p0(q0_if.slave), .p1(q1_if.slave),
    .alu_da(fda), .alu_db(fdb), .alu_ctl(fctl),
    .alu_dc(fdc), .alu_zero(fzf), .alu_ovf(fof), .busy(fbusy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model of the RR instance ----------------
  logic [1:0]    m_valid = '0;
  logic [DW+1:0] m_rsp [2];
  int            m_last = 1;
  bit            m_ok = 1'b0;

  always @(negedge clk) begin : model
    logic [1:0]    rv, rr, el, got, expr;
    logic [DW-1:0] ra [2];
    logic [DW-1:0] rb [2];
    logic [CW-1:0] rc [2];
    int            win;
    rv    = {p1_if.req_valid, p0_if.req_valid};
    rr    = {p1_if.rsp_ready, p0_if.rsp_ready};
    got   = {p1_if.req_ready, p0_if.req_ready};
    ra[0] = p0_if.req_a;  ra[1] = p1_if.req_a;
    rb[0] = p0_if.req_b;  rb[1] = p1_if.req_b;
    rc[0] = p0_if.req_ctl; rc[1] = p1_if.req_ctl;
    if (m_ok) begin
      chk("m_p0_rsp_valid", p0_if.rsp_valid, m_valid[0]);
      chk("m_p1_rsp_valid", p1_if.rsp_valid, m_valid[1]);
      chk("m_p0_rsp", {p0_if.rsp_ovf, p0_if.rsp_zero, p0_if.rsp_data}, m_rsp[0]);
      chk("m_p1_rsp", {p1_if.rsp_ovf, p1_if.rsp_zero, p1_if.rsp_data}, m_rsp[1]);
      chk("m_busy", busy, |m_valid);
    end
    if (rst) begin
      chk("m_rst_ready", got, 2'b00);
      chk("m_rst_alu", {da, db, ctl}, '0);
      m_valid = '0;
      m_rsp[0] = '0;
      m_rsp[1] = '0;
      m_last = 1;
      m_ok = 1'b1;
    end else if (m_ok) begin
      el  = rv & ~(m_valid & ~rr);
      win = -1;
      if (el == 2'b11)  win = (m_last == 1) ? 0 : 1;
      else if (el[0])   win = 0;
      else if (el[1])   win = 1;
      expr = (win == 0) ? 2'b01 : (win == 1) ? 2'b10 : 2'b00;
      chk("m_req_ready", got, expr);
      chk("m_alu_da",  da,  (win >= 0) ? ra[win] : '0);
      chk("m_alu_db",  db,  (win >= 0) ? rb[win] : '0);
      chk("m_alu_ctl", ctl, (win >= 0) ? rc[win] : '0);
      for (int n = 0; n < 2; n++) begin
        if (win == n) begin
          m_valid[n] = 1'b1;
          m_rsp[n]   = alu_f(ra[n], rb[n], rc[n]);
        end else if (rr[n]) begin
          m_valid[n] = 1'b0;
        end
      end
      if (win >= 0) m_last = win;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_p(input int n, input logic v, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic [CW-1:0] c);
    if (n == 0) begin
      p0_if.req_valid = v; p0_if.req_a = a; p0_if.req_b = b; p0_if.req_ctl = c;
    end else begin
      p1_if.req_valid = v; p1_if.req_a = a; p1_if.req_b = b; p1_if.req_ctl = c;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  logic [1:0] pv, acc;

  initial begin
    set_p(0, 1'b1, 32'd5, 32'd7, 4'd0);
    set_p(1, 1'b1, 32'd9, 32'd9, 4'd0);
    p0_if.rsp_ready = 1'b1; p1_if.rsp_ready = 1'b1;
    q0_if.req_valid = 1'b0; q0_if.req_a = '0; q0_if.req_b = '0; q0_if.req_ctl = '0;
    q1_if.req_valid = 1'b0; q1_if.req_a = '0; q1_if.req_b = '0; q1_if.req_ctl = '0;
    q0_if.rsp_ready = 1'b1; q1_if.rsp_ready = 1'b1;

    // reset state with requests pending
    step();
    sample();
    chk("rst_p0_ready", p0_if.req_ready, 1'b0);
    chk("rst_p1_ready", p1_if.req_ready, 1'b0);
    chk("rst_alu_da", da, 32'd0);
    chk("rst_p0_rsp_valid", p0_if.rsp_valid, 1'b0);
    chk("rst_p0_rsp_data", p0_if.rsp_data, 32'd0);
    chk("rst_busy", busy, 1'b0);

    // 1: single add, one-cycle latency
    step();
    rst = 1'b0;
    set_p(1, 1'b0, '0, '0, '0);
    sample();
    chk("t1_p0_ready", p0_if.req_ready, 1'b1);
    chk("t1_alu_da", da, 32'd5);
    step();
    set_p(0, 1'b0, '0, '0, '0);
    sample();
    chk("t1_rsp_valid", p0_if.rsp_valid, 1'b1);
    chk("t1_rsp_data", p0_if.rsp_data, 32'd12);
    chk("t1_rsp_zero", p0_if.rsp_zero, 1'b0);
    chk("t1_rsp_ovf", p0_if.rsp_ovf, 1'b0);

    // 2: conflict after reset, port 0 first
    step();
    do_reset();
    set_p(0, 1'b1, 32'd3, 32'd3, 4'd2);
    set_p(1, 1'b1, 32'd1, 32'd1, 4'd0);
    sample();
    chk("t2_p0_ready", p0_if.req_ready, 1'b1);
    chk("t2_p1_ready", p1_if.req_ready, 1'b0);
    step();
    set_p(0, 1'b0, '0, '0, '0);
    sample();
    chk("t2_p1_ready_next", p1_if.req_ready, 1'b1);
    chk("t2_p0_rsp_zero", p0_if.rsp_zero, 1'b1);
    chk("t2_p0_rsp_data", p0_if.rsp_data, 32'd0);
    step();
    set_p(1, 1'b0, '0, '0, '0);
    sample();
    chk("t2_p1_rsp_valid", p1_if.rsp_valid, 1'b1);
    chk("t2_p1_rsp_data", p1_if.rsp_data, 32'd2);

    // 3: signed overflow reported by the ALU passes through
    step();
    set_p(1, 1'b1, 32'h7FFF_FFFF, 32'd1, 4'd1);
    sample();
    chk("t3_p1_ready", p1_if.req_ready, 1'b1);
    step();
    set_p(1, 1'b0, '0, '0, '0);
    sample();
    chk("t3_p1_rsp_data", p1_if.rsp_data, 32'h8000_0000);
    chk("t3_p1_rsp_ovf", p1_if.rsp_ovf, 1'b1);

    // 4: continuous contention, RR alternates, fixed priority always port 0
    step();
    do_reset();
    set_p(0, 1'b1, 32'd2, 32'd3, 4'd4);
    set_p(1, 1'b1, 32'd6, 32'd1, 4'd5);
    q0_if.req_valid = 1'b1; q0_if.req_a = 32'd11;
    q1_if.req_valid = 1'b1; q1_if.req_a = 32'd22;
    for (int k = 0; k < 6; k++) begin
      sample();
      chk("t4_rr_p0_ready", p0_if.req_ready, (k % 2) == 0);
      chk("t4_rr_p1_ready", p1_if.req_ready, (k % 2) == 1);
      chk("t4_fp_p0_ready", q0_if.req_ready, 1'b1);
      chk("t4_fp_p1_ready", q1_if.req_ready, 1'b0);
      if (k > 0) chk("t4_fp_busy", fbusy, 1'b1);
      step();
    end
    set_p(0, 1'b0, '0, '0, '0);
    set_p(1, 1'b0, '0, '0, '0);
    q0_if.req_valid = 1'b0;
    q1_if.req_valid = 1'b0;

    // 5: full buffer blocks only its own port; pop+refill in one cycle
    do_reset();
    set_p(0, 1'b1, 32'd10, 32'd20, 4'd0);
    p0_if.rsp_ready = 1'b0;
    sample();
    chk("t5_p0_first_ready", p0_if.req_ready, 1'b1);
    step();
    set_p(0, 1'b1, 32'd1, 32'd1, 4'd0);
    for (int k = 0; k < 3; k++) begin
      set_p(1, 1'b1, 32'(k), 32'd4, 4'd0);
      sample();
      chk("t5_p0_blocked", p0_if.req_ready, 1'b0);
      chk("t5_p0_hold", p0_if.rsp_data, 32'd30);
      chk("t5_p0_rsp_valid", p0_if.rsp_valid, 1'b1);
      chk("t5_p1_ready", p1_if.req_ready, 1'b1);
      step();
    end
    p0_if.rsp_ready = 1'b1;
    sample();
    chk("t5_refill_ready", p0_if.req_ready, 1'b1);
    chk("t5_refill_p1_ready", p1_if.req_ready, 1'b0);
    chk("t5_old_data", p0_if.rsp_data, 32'd30);
    step();
    set_p(0, 1'b0, '0, '0, '0);
    p0_if.rsp_ready = 1'b0;
    sample();
    chk("t5_new_valid", p0_if.rsp_valid, 1'b1);
    chk("t5_new_data", p0_if.rsp_data, 32'd2);
    chk("t5_p1_late_ready", p1_if.req_ready, 1'b1);
    step();
    set_p(1, 1'b0, '0, '0, '0);
    p1_if.rsp_ready = 1'b0;

    // 6: reset with both buffers full and both ports requesting
    set_p(0, 1'b1, 32'd4, 32'd4, 4'd0);
    set_p(1, 1'b1, 32'd4, 32'd4, 4'd0);
    sample();
    chk("t6_busy", busy, 1'b1);
    chk("t6_p0_blocked", p0_if.req_ready, 1'b0);
    chk("t6_p1_blocked", p1_if.req_ready, 1'b0);
    step();
    rst = 1'b1;
    sample();
    chk("t6_rst_ready", {p1_if.req_ready, p0_if.req_ready}, 2'b00);
    chk("t6_rst_alu", da, 32'd0);
    step();
    sample();
    chk("t6_p0_rsp_valid", p0_if.rsp_valid, 1'b0);
    chk("t6_p1_rsp_valid", p1_if.rsp_valid, 1'b0);
    chk("t6_ready", {p1_if.req_ready, p0_if.req_ready}, 2'b00);
    chk("t6_busy_clr", busy, 1'b0);
    step();
    rst = 1'b0;
    p0_if.rsp_ready = 1'b1;
    p1_if.rsp_ready = 1'b1;
    sample();
    chk("t6_first_p0", p0_if.req_ready, 1'b1);
    chk("t6_first_p1", p1_if.req_ready, 1'b0);

    // randomized traffic, requesters obey hold-until-ready
    pv  = 2'b11;
    acc = {p1_if.req_ready, p0_if.req_ready};
    for (int c = 0; c < 3000; c++) begin
      step();
      rst = ($urandom_range(0, 99) == 0);
      for (int n = 0; n < 2; n++) begin
        if (!pv[n] || acc[n]) begin
          pv[n] = ($urandom_range(0, 3) != 0);
          set_p(n, pv[n], ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : 32'($urandom),
                32'($urandom), 4'($urandom_range(0, 8)));
        end
      end
      p0_if.rsp_ready = ($urandom_range(0, 3) != 0);
      p1_if.rsp_ready = ($urandom_range(0, 2) != 0);
      sample();
      acc = {p1_if.req_ready, p0_if.req_ready};
    end

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
